// File: rtl/fp_exe_responder.sv
// fp_exe_responder: responder-side front end for the FP execution unit.
// A request is accepted over valid/ready and issued to fp_unit as a one-cycle
// enable pulse. Its completion, or a watchdog timeout, is queued in a small
// response FIFO that the initiator drains. Only one operation is outstanding.

package fp_exe_pkg;
    // One-hot operation select understood by fp_unit.
    typedef struct packed {
        logic fmadd, fmsub, fnmsub, fnmadd;
        logic fadd, fsub, fmul, fdiv, fsqrt;
        logic fsgnj, fcmp, fmax, fclass;
        logic fcvt_f2i, fcvt_i2f, fcvt_f2f;
        logic fmv_f2i, fmv_i2f;
    } fp_operation_type;

    localparam fp_operation_type init_fp_operation = '0;
endpackage

module fp_exe_responder
    import fp_exe_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 256
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [TAG_W-1:0] req_tag,
    input  logic [63:0]      req_data1,
    input  logic [63:0]      req_data2,
    input  logic [63:0]      req_data3,
    input  logic [1:0]       req_fmt,
    input  logic [2:0]       req_rm,
    input  fp_operation_type req_op,
    output logic [63:0]      exe_data1,
    output logic [63:0]      exe_data2,
    output logic [63:0]      exe_data3,
    output logic [1:0]       exe_fmt,
    output logic [2:0]       exe_rm,
    output fp_operation_type exe_op,
    output logic             exe_enable,
    output logic             exe_clear,
    input  logic [63:0]      exe_result,
    input  logic [4:0]       exe_flags,
    input  logic             exe_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [TAG_W-1:0] rsp_tag,
    output logic [63:0]      rsp_result,
    output logic [4:0]       rsp_flags,
    output logic             rsp_timeout,
    output logic             busy,
    output logic             err_spurious
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0]  WD_MAX = WD_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [63:0]      result;
        logic [4:0]       flags;
        logic             timeout;
    } rsp_entry_t;

    state_t           state_q, state_d;
    logic [WD_W-1:0]  wd_q;
    logic [TAG_W-1:0] tag_q;
    logic             accept, push, pop;
    rsp_entry_t       push_entry;
    rsp_entry_t       mem [DEPTH];
    rsp_entry_t       head_q;
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q, rd_ptr_nxt;
    logic [CNT_W-1:0] count_q;

    assign exe_clear    = clear;
    assign busy         = (state_q == S_WAIT);
    assign rsp_valid    = (count_q != '0);
    assign pop          = rsp_valid && rsp_ready;
    assign rd_ptr_nxt   = rd_ptr_q + PTR_W'(1);
    assign rsp_tag      = head_q.tag;
    assign rsp_result   = head_q.result;
    assign rsp_flags    = head_q.flags;
    assign rsp_timeout  = head_q.timeout;

    // State register.
    // NOTE: every clocked block uses non-blocking (<=) assignments so all flops
    // update together from pre-edge values, independent of block order.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)     state_q <= S_IDLE;
        else            state_q <= state_d;
    end

    // Next-state logic: clear wins over everything else.
    always_comb begin
        // NOTE: a default assignment before any branch keeps this block free of latches.
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = S_WAIT;
            S_WAIT: if (push)   state_d = S_IDLE;
            default:            state_d = S_IDLE;
        endcase
        if (clear) state_d = S_IDLE;
    end

    // Output logic: handshake, and the entry pushed on completion or timeout.
    // The space check at accept reserves the slot the completion will use.
    always_comb begin
        req_ready  = (state_q == S_IDLE) && (count_q < CNT_FULL) && !clear && reset;
        accept     = req_valid && req_ready;
        push       = 1'b0;
        push_entry = '0;
        if (state_q == S_WAIT && !clear) begin
            if (exe_ready) begin
                push       = 1'b1;
                push_entry = '{tag: tag_q, result: exe_result, flags: exe_flags, timeout: 1'b0};
            end else if (wd_q == WD_MAX) begin
                push       = 1'b1;
                push_entry = '{tag: tag_q, result: '0, flags: '0, timeout: 1'b1};
            end
        end
    end

    // Issue registers: operands captured on accept and held until the next one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exe_data1  <= '0;
            exe_data2  <= '0;
            exe_data3  <= '0;
            exe_fmt    <= '0;
            exe_rm     <= '0;
            exe_op     <= init_fp_operation;
            exe_enable <= 1'b0;
            tag_q      <= '0;
        end else if (clear) begin
            exe_enable <= 1'b0;
            exe_op     <= init_fp_operation;
        end else begin
            exe_enable <= accept;
            if (accept) begin
                exe_data1 <= req_data1;
                exe_data2 <= req_data2;
                exe_data3 <= req_data3;
                exe_fmt   <= req_fmt;
                exe_rm    <= req_rm;
                exe_op    <= req_op;
                tag_q     <= req_tag;
            end
        end
    end

    // Watchdog counter and sticky spurious-completion flag.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wd_q         <= '0;
            err_spurious <= 1'b0;
        end else if (clear) begin
            wd_q         <= '0;
            err_spurious <= 1'b0;
        end else begin
            if (accept)                          wd_q <= '0;
            else if (state_q == S_WAIT && !push) wd_q <= wd_q + WD_W'(1);
            if (state_q == S_IDLE && exe_ready)  err_spurious <= 1'b1;
        end
    end

    // Response storage array.
    // NOTE: the array has no reset; only the pointers, count and head register
    // are reset, and an entry is never read before it has been written.
    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr_q] <= push_entry;
    end

    // FIFO pointers, occupancy and registered head entry.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_nxt;
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (pop) begin
                if (count_q > CNT_W'(1)) head_q <= mem[rd_ptr_nxt];
                else if (push)           head_q <= push_entry;
            end else if (push && count_q == '0) begin
                head_q <= push_entry;
            end
        end
    end

endmodule

// File: tb/tb_fp_exe_responder.sv
// Testbench for fp_exe_responder: scenario tasks with a response scoreboard.
module tb_fp_exe_responder;
    import fp_exe_pkg::*;

    localparam int DEPTH   = 4;
    localparam int TAG_W   = 4;
    localparam int TIMEOUT = 8;

    logic             clock, reset, clear;
    logic             req_valid, req_ready;
    logic [TAG_W-1:0] req_tag;
    logic [63:0]      req_data1, req_data2, req_data3;
    logic [1:0]       req_fmt;
    logic [2:0]       req_rm;
    fp_operation_type req_op;
    logic [63:0]      exe_data1, exe_data2, exe_data3;
    logic [1:0]       exe_fmt;
    logic [2:0]       exe_rm;
    fp_operation_type exe_op;
    logic             exe_enable, exe_clear;
    logic [63:0]      exe_result;
    logic [4:0]       exe_flags;
    logic             exe_ready;
    logic             rsp_valid, rsp_ready;
    logic [TAG_W-1:0] rsp_tag;
    logic [63:0]      rsp_result;
    logic [4:0]       rsp_flags;
    logic             rsp_timeout, busy, err_spurious;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [63:0]      result;
        logic [4:0]       flags;
        logic             timeout;
    } exp_t;

    exp_t sb [$];
    int   n_cmp = 0;
    int   n_mis = 0;

    fp_exe_responder #(.DEPTH(DEPTH), .TAG_W(TAG_W), .TIMEOUT(TIMEOUT)) dut (
        .clock(clock), .reset(reset), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
        .req_data1(req_data1), .req_data2(req_data2), .req_data3(req_data3),
        .req_fmt(req_fmt), .req_rm(req_rm), .req_op(req_op),
        .exe_data1(exe_data1), .exe_data2(exe_data2), .exe_data3(exe_data3),
        .exe_fmt(exe_fmt), .exe_rm(exe_rm), .exe_op(exe_op),
        .exe_enable(exe_enable), .exe_clear(exe_clear),
        .exe_result(exe_result), .exe_flags(exe_flags), .exe_ready(exe_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tag(rsp_tag),
        .rsp_result(rsp_result), .rsp_flags(rsp_flags), .rsp_timeout(rsp_timeout),
        .busy(busy), .err_spurious(err_spurious)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1);
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clock);
    endtask

    function automatic fp_operation_type mk_op(input int sel);
        fp_operation_type op;
        op = init_fp_operation;
        case (sel)
            0: op.fadd = 1'b1;
            1: op.fmul = 1'b1;
            2: op.fdiv = 1'b1;
            default: op.fsqrt = 1'b1;
        endcase
        return op;
    endfunction

    // Present a request and wait (bounded) until it is accepted.
    // Returns at the falling edge of the cycle after the accepting edge.
    task automatic issue(input logic [TAG_W-1:0] tag, input int sel, input logic [1:0] fmt,
                         input logic [63:0] d1, input logic [63:0] d2, input string name);
        int budget;
        budget    = 0;
        req_valid = 1'b1;
        req_tag   = tag;
        req_data1 = d1;
        req_data2 = d2;
        req_data3 = 64'h0;
        req_fmt   = fmt;
        req_rm    = 3'd0;
        req_op    = mk_op(sel);
        while (req_ready !== 1'b1 && budget < 20) begin
            step();
            budget++;
        end
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL %s_accept: req_ready=%b, required 1", name, req_ready);
        end
        step();
        req_valid = 1'b0;
    endtask

    // Drive one fp_unit completion pulse; optionally expect a response.
    task automatic complete(input logic [TAG_W-1:0] tag, input logic [63:0] res,
                            input logic [4:0] flg, input bit expect_rsp);
        exe_ready  = 1'b1;
        exe_result = res;
        exe_flags  = flg;
        if (expect_rsp) sb.push_back('{tag: tag, result: res, flags: flg, timeout: 1'b0});
        step();
        exe_ready  = 1'b0;
        exe_result = '0;
        exe_flags  = '0;
    endtask

    // Wait (bounded) for a response, compare it with the scoreboard head, pop it.
    task automatic pop_check(input string name);
        exp_t exp_e, got;
        int   budget;
        budget = 0;
        while (rsp_valid !== 1'b1 && budget < 50) begin
            step();
            budget++;
        end
        n_cmp++;
        got = {rsp_tag, rsp_result, rsp_flags, rsp_timeout};
        if (rsp_valid !== 1'b1) begin
            n_mis++;
            $display("FAIL %s_valid: rsp_valid=%b, required 1", name, rsp_valid);
        end else if (sb.size() == 0) begin
            n_mis++;
            $display("FAIL %s_extra: unexpected response tag=%0d", name, rsp_tag);
        end else begin
            exp_e = sb.pop_front();
            if (got !== exp_e) begin
                n_mis++;
                $display("FAIL %s_rsp: got tag=%0d res=%h flg=%h to=%b, required tag=%0d res=%h flg=%h to=%b",
                         name, got.tag, got.result, got.flags, got.timeout,
                         exp_e.tag, exp_e.result, exp_e.flags, exp_e.timeout);
            end
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; clear = 1'b0; req_valid = 1'b1; req_tag = '0;
        req_data1 = '0; req_data2 = '0; req_data3 = '0; req_fmt = '0; req_rm = '0;
        req_op = init_fp_operation; exe_result = '0; exe_flags = '0; exe_ready = 1'b0;
        rsp_ready = 1'b0;
        step();
        step();
        n_cmp++;
        if ({req_ready, exe_enable, busy, rsp_valid, err_spurious} !== 5'b0) begin
            n_mis++;
            $display("FAIL reset_ctrl: rdy/en/busy/rv/err=%b, required 00000",
                     {req_ready, exe_enable, busy, rsp_valid, err_spurious});
        end
        n_cmp++;
        if ({exe_op, exe_data1, exe_fmt, rsp_tag, rsp_result} !== '0) begin
            n_mis++;
            $display("FAIL reset_regs: op=%h d1=%h fmt=%h tag=%h res=%h, required all 0",
                     exe_op, exe_data1, exe_fmt, rsp_tag, rsp_result);
        end
        reset     = 1'b1;
        req_valid = 1'b0;
        #1;
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL reset_release: req_ready=%b, required 1", req_ready);
        end
        step();
    endtask

    task automatic test_single();
        issue(4'd3, 0, 2'd0, 64'h3F80_0000, 64'h3F80_0000, "single");
        n_cmp++;
        if ({exe_enable, busy, exe_fmt, exe_op} !== {1'b1, 1'b1, 2'd0, mk_op(0)}) begin
            n_mis++;
            $display("FAIL single_issue: en=%b busy=%b fmt=%0d op=%h, required 1 1 0 %h",
                     exe_enable, busy, exe_fmt, exe_op, mk_op(0));
        end
        step();
        n_cmp++;
        if ({exe_enable, busy} !== 2'b01) begin
            n_mis++;
            $display("FAIL single_pulse: en=%b busy=%b, required 0 1", exe_enable, busy);
        end
        step();
        complete(4'd3, 64'h4000_0000, 5'd0, 1'b1);
        n_cmp++;
        if ({rsp_valid, busy, req_ready} !== 3'b101) begin
            n_mis++;
            $display("FAIL single_done: rv=%b busy=%b rdy=%b, required 1 0 1", rsp_valid, busy, req_ready);
        end
        pop_check("single");
        n_cmp++;
        if ({exe_data1, exe_data2, exe_op} !== {64'h3F80_0000, 64'h3F80_0000, mk_op(0)}) begin
            n_mis++;
            $display("FAIL single_hold: d1=%h d2=%h op=%h, required operands held", exe_data1, exe_data2, exe_op);
        end
    endtask

    task automatic test_full();
        rsp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            issue(TAG_W'(i), 1, 2'd1, 64'(i), 64'(i + 10), "full");
            complete(TAG_W'(i), 64'h1000 + 64'(i), 5'(i + 1), 1'b1);
        end
        req_valid = 1'b1;
        req_tag   = 4'd4;
        #1;
        n_cmp++;
        if (req_ready !== 1'b0) begin
            n_mis++;
            $display("FAIL full_block: req_ready=%b, required 0", req_ready);
        end
        step();
        n_cmp++;
        if ({req_ready, busy} !== 2'b00) begin
            n_mis++;
            $display("FAIL full_hold: rdy=%b busy=%b, required 0 0", req_ready, busy);
        end
        pop_check("full_tag0");
        n_cmp++;
        if (req_ready !== 1'b1) begin
            n_mis++;
            $display("FAIL full_reopen: req_ready=%b, required 1", req_ready);
        end
        issue(4'd4, 2, 2'd1, 64'h44, 64'h55, "full_tag4");
        complete(4'd4, 64'h1004, 5'h1F, 1'b1);
        for (int i = 1; i <= 4; i++) pop_check($sformatf("full_tag%0d", i));
    endtask

    task automatic test_timeout();
        int n_busy;
        n_busy = 0;
        issue(4'd5, 2, 2'd1, 64'h5, 64'h6, "timeout");
        sb.push_back('{tag: 4'd5, result: 64'h0, flags: 5'h0, timeout: 1'b1});
        while (busy === 1'b1 && n_busy < 40) begin
            n_busy++;
            step();
        end
        n_cmp++;
        if (n_busy != TIMEOUT) begin
            n_mis++;
            $display("FAIL timeout_busy: busy for %0d cycles, required %0d", n_busy, TIMEOUT);
        end
        complete(4'd5, 64'hDEAD, 5'h3, 1'b0);
        n_cmp++;
        if ({err_spurious, rsp_valid} !== 2'b11) begin
            n_mis++;
            $display("FAIL timeout_late: err=%b rv=%b, required 1 1", err_spurious, rsp_valid);
        end
        pop_check("timeout");
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL timeout_count: rsp_valid=%b after one pop, required 0", rsp_valid);
        end
    endtask

    task automatic test_push_pop();
        exp_t exp6, exp7, got;
        issue(4'd6, 0, 2'd0, 64'h60, 64'h61, "pp6");
        complete(4'd6, 64'hA6, 5'h06, 1'b1);
        issue(4'd7, 1, 2'd0, 64'h70, 64'h71, "pp7");
        exp6 = sb.pop_front();
        got  = {rsp_tag, rsp_result, rsp_flags, rsp_timeout};
        n_cmp++;
        if (got !== exp6) begin
            n_mis++;
            $display("FAIL pp_old_head: got tag=%0d res=%h, required tag=%0d res=%h",
                     got.tag, got.result, exp6.tag, exp6.result);
        end
        exp7 = '{tag: 4'd7, result: 64'hB7, flags: 5'h17, timeout: 1'b0};
        sb.push_back(exp7);
        rsp_ready  = 1'b1;
        exe_ready  = 1'b1;
        exe_result = 64'hB7;
        exe_flags  = 5'h17;
        step();
        rsp_ready  = 1'b0;
        exe_ready  = 1'b0;
        got = {rsp_tag, rsp_result, rsp_flags, rsp_timeout};
        n_cmp++;
        if (rsp_valid !== 1'b1 || got !== exp7) begin
            n_mis++;
            $display("FAIL pp_new_head: rv=%b tag=%0d res=%h flg=%h, required 1 tag=7 res=b7 flg=17",
                     rsp_valid, got.tag, got.result, got.flags);
        end
        pop_check("pp_tag7");
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_mis++;
            $display("FAIL pp_count: rsp_valid=%b, required 0", rsp_valid);
        end
    endtask

    task automatic test_clear();
        issue(4'd8, 0, 2'd0, 64'h80, 64'h81, "clr8");
        complete(4'd8, 64'hC8, 5'h08, 1'b0);
        issue(4'd9, 1, 2'd1, 64'h90, 64'h91, "clr9");
        step();
        clear     = 1'b1;
        req_valid = 1'b1;
        req_tag   = 4'd12;
        #1;
        n_cmp++;
        if ({req_ready, exe_clear} !== 2'b01) begin
            n_mis++;
            $display("FAIL clear_gate: rdy=%b exe_clear=%b, required 0 1", req_ready, exe_clear);
        end
        step();
        clear     = 1'b0;
        req_valid = 1'b0;
        n_cmp++;
        if ({busy, rsp_valid, err_spurious, exe_enable} !== 4'b0 || exe_op !== init_fp_operation) begin
            n_mis++;
            $display("FAIL clear_state: busy=%b rv=%b err=%b en=%b op=%h, required all 0",
                     busy, rsp_valid, err_spurious, exe_enable, exe_op);
        end
        step();
        n_cmp++;
        if ({busy, exe_enable} !== 2'b00) begin
            n_mis++;
            $display("FAIL clear_noaccept: busy=%b en=%b, required 0 0", busy, exe_enable);
        end
        complete(4'd9, 64'hC9, 5'h09, 1'b0);
        n_cmp++;
        if ({err_spurious, rsp_valid} !== 2'b10) begin
            n_mis++;
            $display("FAIL clear_late: err=%b rv=%b, required 1 0", err_spurious, rsp_valid);
        end
    endtask

    task automatic test_async_reset();
        issue(4'd11, 0, 2'd0, 64'hB0, 64'hB1, "ar11");
        complete(4'd11, 64'hCB, 5'h0B, 1'b0);
        issue(4'd10, 1, 2'd0, 64'hA0, 64'hA1, "ar10");
        req_valid = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        n_cmp++;
        if ({exe_enable, busy, rsp_valid, req_ready} !== 4'b0) begin
            n_mis++;
            $display("FAIL areset_now: en=%b busy=%b rv=%b rdy=%b, required 0000",
                     exe_enable, busy, rsp_valid, req_ready);
        end
        step();
        step();
        reset     = 1'b1;
        req_valid = 1'b0;
        #1;
        n_cmp++;
        if ({req_ready, rsp_valid, err_spurious} !== 3'b100) begin
            n_mis++;
            $display("FAIL areset_release: rdy=%b rv=%b err=%b, required 1 0 0",
                     req_ready, rsp_valid, err_spurious);
        end
        step();
        complete(4'd10, 64'hCA, 5'h0A, 1'b0);
        n_cmp++;
        if ({err_spurious, rsp_valid} !== 2'b10) begin
            n_mis++;
            $display("FAIL areset_late: err=%b rv=%b, required 1 0", err_spurious, rsp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_full();
        test_timeout();
        test_push_pop();
        test_clear();
        test_async_reset();
        n_cmp++;
        if (sb.size() != 0) begin
            n_mis++;
            $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
